word_byte_serializer: RTL and testbench
=======================================

// Module: word_byte_serializer
// PURPOSE
//  Synthesizable word-to-byte serializer. Buffers DATA_W-bit words in a small FIFO and emits
//  them one byte per cycle over a valid/ready stream, in configurable byte order.
//  Sits between a word-wide producer (register/DMA path) and a byte-wide sink (UART/file-dump
//  bridge). It is the hardware counterpart of the bench-side byte dump.
// PARAMETERS
//  DATA_W     32  input word width; multiple of 8 and >= 8, else elaboration $error
//  DEPTH      4   word FIFO entries; power of 2 and >= 2, else elaboration $error
//  MSB_FIRST  1   1: byte 0 out = data[DATA_W-1 -: 8]; 0: byte 0 out = data[7:0]
//  CNT_W      32  width of the emitted-byte counter
// PORTS
//  clk        in   1                     rising-edge clock
//  rst_n      in   1                     asynchronous, active-low reset
//  in_valid   in   1                     input word valid
//  in_ready   out  1                     FIFO not full (= !full, combinational from state)
//  in_data    in   DATA_W                input word
//  in_last    in   1                     word ends a packet
//  out_valid  out  1                     out_byte valid
//  out_ready  in   1                     sink accepts byte
//  out_byte   out  8                     current byte
//  out_last   out  1                     final byte of a word tagged in_last
//  level      out  $clog2(DEPTH)+1       words held in FIFO, shift stage excluded
//  byte_cnt   out  CNT_W                 bytes accepted by sink since reset, wraps to 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, shift stage empty, byte index 0.
//    out_valid=0, out_byte=0, out_last=0, level=0, byte_cnt=0. in_ready=1.
//  - Push: in_valid&&in_ready at an edge writes {in_last,in_data}. No push when full, even if
//    a pop happens in the same cycle.
//  - Shift stage: holds one word, byte index idx in 0..NB-1 (NB = DATA_W/8).
//    Loads from the FIFO on an edge when the FIFO is non-empty and either:
//    the stage is empty, or the stage's last byte (idx=NB-1) is accepted at that edge.
//    Back-to-back words therefore have no bubble.
//  - Latency: a word pushed into an empty FIFO with an empty stage at edge k gives
//    out_valid=1 after edge k+1. Its NB bytes take >= NB cycles.
//  - Handshake: a byte transfers on out_valid&&out_ready. On transfer, idx increments and
//    byte_cnt increments. out_byte and out_last stay stable while out_valid&&!out_ready.
//    out_valid never drops without a transfer.
//  - Byte order: out_byte = word byte idx, counted from the MSB if MSB_FIRST=1, else from the LSB.
//  - out_last = stored last flag && idx==NB-1.
//  - Stage empties after the last byte transfers when the FIFO is empty. out_valid falls the
//    following cycle; out_byte holds its last value.
//  - level: +1 on push-only, -1 on load-only, unchanged on push&&load. Range 0..DEPTH.
//  - Wrap: FIFO pointers wrap modulo DEPTH. byte_cnt wraps from 2^CNT_W-1 to 0 silently.
//  - Reset mid-packet: all buffered words and any partial word are discarded.
//    No out_last is emitted for a packet cut short by reset.
//  - NB==1 (DATA_W=8): each load emits exactly one byte; idx is constant 0.
// STRUCTURE
//  - ser_pkg:
//    - BYTE_W=8
//    - function nbytes(DATA_W)
//    - function byte_sel(word, idx, msb_first)
//    - typedef of the FIFO entry {last, data}
//  - Sub-module sync_fifo: DEPTH x (DATA_W+1), async active-low reset, with full/empty/level.
//    The top holds the shift stage, idx counter, byte_cnt and output muxing.
// TESTING
//  1. Reset, then push 32'h01234567 and 32'h89ABCDEF (MSB_FIRST=1), out_ready=1
//     -> bytes 01 23 45 67 89 AB CD EF on 8 consecutive cycles, no gap; byte_cnt=8.
//  2. MSB_FIRST=0, push 32'hABCDEF01 with in_last=1
//     -> bytes 01 EF CD AB; out_last only on AB.
//  3. out_ready=0, push 5 words into DEPTH=4
//     -> after 4 FIFO pushes plus 1 loaded into the stage, level=4 and in_ready=0; out_byte held
//        stable. Release out_ready -> all 20 bytes emerge in order.
//  4. Random out_ready stalls (50%) over 1000 random words
//     -> scoreboard byte stream matches the model; level never exceeds DEPTH.
//  5. Assert rst_n=0 mid-word (after 2 of 4 bytes)
//     -> out_valid=0, level=0, byte_cnt=0 immediately. Next word starts at its byte 0.
//  6. Preload byte_cnt near wrap (CNT_W=4), send 20 bytes
//     -> byte_cnt reads 4. DATA_W=8 build: one byte per word, out_last per tagged word.

Source files
------------

// File: rtl/word_byte_serializer_pkg.sv
// Shared constants, stage state encoding and byte-lane helpers for the
// word-to-byte serializer.
package word_byte_serializer_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MAX_W  = 1024;

  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } stage_state_t;

  function automatic int unsigned nbytes(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // Byte idx of a zero-extended word, counted from the MSB end when msb_first.
  function automatic logic [BYTE_W-1:0] byte_sel(input wide_t       word,
                                                 input int unsigned nb,
                                                 input int unsigned idx,
                                                 input logic        msb_first);
    int unsigned pos;
    wide_t       sh;
    pos = msb_first ? (nb - 1 - idx) : idx;
    sh  = word >> (pos * BYTE_W);
    return sh[BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/word_byte_serializer_fifo.sv
// Synchronous word FIFO with full/empty/level; pushes are refused while full
// regardless of a same-cycle pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/word_byte_serializer.sv
// Word-to-byte serializer: FIFO-buffered words are emitted one byte per
// accepted cycle through a single shift stage, in configurable byte order.
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_byte,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         byte_cnt
);

  localparam int unsigned NB    = nbytes(DATA_W);
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  if (DATA_W < BYTE_W || (DATA_W % BYTE_W) != 0 || DATA_W > MAX_W) begin : g_bad_data_w
    $error("word_byte_serializer: DATA_W must be a multiple of 8 and >= 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("word_byte_serializer: DEPTH must be a power of 2 and >= 2");
  end

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           wr_entry;
  entry_t           rd_entry;
  entry_t           stage_q;
  stage_state_t     state_q;
  stage_state_t     state_d;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             xfer;
  logic             stage_done;
  logic             load;
  wide_t            word_ext;

  assign wr_entry = {in_last, in_data};
  assign in_ready = !fifo_full;
  assign byte_cnt = cnt_q;

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (wr_entry),
    .pop   (load),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Reload on the same edge the final byte leaves so consecutive words have no bubble.
  assign xfer       = (state_q == ST_HOLD) && out_ready;
  assign stage_done = xfer && (idx_q == LAST_IDX);
  assign load       = !fifo_empty && ((state_q == ST_EMPTY) || stage_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_HOLD;
      ST_HOLD:  if (stage_done && !load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Stage word and index are left untouched when the stage empties, so out_byte
  // keeps showing the final byte until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (load) begin
        stage_q <= rd_entry;
        idx_q   <= '0;
      end else if (xfer && !stage_done) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    word_ext               = '0;
    word_ext[DATA_W-1:0]   = stage_q.data;
    out_valid              = (state_q == ST_HOLD);
    out_byte               = byte_sel(word_ext, NB, 32'(idx_q), MSB_FIRST != 0);
    out_last               = out_valid && stage_q.last && (idx_q == LAST_IDX);
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Directed bench for word_byte_serializer: three builds (MSB-first 32-bit,
// LSB-first 32-bit, 8-bit with a 4-bit byte counter).
module tb_word_byte_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_byte;
  logic [2:0]  a_level;
  logic [31:0] a_byte_cnt;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_data;
  logic [7:0]  b_out_byte;
  logic [2:0]  b_level;
  logic [31:0] b_byte_cnt;

  logic        c_in_valid, c_in_ready, c_in_last, c_out_valid, c_out_ready, c_out_last;
  logic [7:0]  c_in_data;
  logic [7:0]  c_out_byte;
  logic [2:0]  c_level;
  logic [3:0]  c_byte_cnt;

  word_byte_serializer #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_last(a_in_last), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_byte(a_out_byte), .out_last(a_out_last),
    .level(a_level), .byte_cnt(a_byte_cnt));

  word_byte_serializer #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_byte(b_out_byte), .out_last(b_out_last),
    .level(b_level), .byte_cnt(b_byte_cnt));

  word_byte_serializer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_byte(c_out_byte), .out_last(c_out_last),
    .level(c_level), .byte_cnt(c_byte_cnt));

  function automatic logic [7:0] c_word(input int i);
    int v;
    v = (i * 37 + 5) % 256;
    return v[7:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_out_ready = 0;
    c_in_valid = 0; c_in_last = 0; c_in_data = '0; c_out_ready = 0;
    repeat (2) @(negedge clk);
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    vectors++; if (a_out_byte !== 8'h00) begin miscompares++; $display("FAIL reset_out_byte: got %h want 00", a_out_byte); end
    vectors++; if (a_out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %b want 0", a_out_last); end
    vectors++; if (a_level !== 3'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", a_level); end
    vectors++; if (a_byte_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_byte_cnt: got %0d want 0", a_byte_cnt); end
    vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    vectors++; if (b_out_valid !== 1'b0 || b_level !== 3'd0 || b_in_ready !== 1'b1 || b_out_last !== 1'b0)
      begin miscompares++; $display("FAIL reset_b: valid=%b level=%0d ready=%b last=%b want 0/0/1/0", b_out_valid, b_level, b_in_ready, b_out_last); end
    vectors++; if (c_out_valid !== 1'b0 || c_level !== 3'd0 || c_in_ready !== 1'b1 || c_byte_cnt !== 4'd0)
      begin miscompares++; $display("FAIL reset_c: valid=%b level=%0d ready=%b cnt=%0d want 0/0/1/0", c_out_valid, c_level, c_in_ready, c_byte_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_msb_order();
    logic [7:0] exp [8];
    exp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
    @(negedge clk);
    a_out_ready = 1; a_in_valid = 1; a_in_data = 32'h01234567; a_in_last = 0;
    @(negedge clk);
    a_in_data = 32'h89ABCDEF;
    @(negedge clk);
    a_in_valid = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (a_out_valid !== 1'b1 || a_out_byte !== exp[i] || a_out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL msb_byte%0d: got valid=%b byte=%h last=%b want 1/%h/0", i, a_out_valid, a_out_byte, a_out_last, exp[i]);
      end
      @(negedge clk);
    end
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL msb_drain_valid: got %b want 0", a_out_valid); end
    vectors++; if (a_out_byte !== 8'hEF) begin miscompares++; $display("FAIL msb_hold_byte: got %h want ef", a_out_byte); end
    vectors++; if (a_byte_cnt !== 32'd8) begin miscompares++; $display("FAIL msb_byte_cnt: got %0d want 8", a_byte_cnt); end
  endtask

  task automatic test_lsb_last();
    logic [7:0] exp [4];
    logic       expl [4];
    exp  = '{8'h01, 8'hEF, 8'hCD, 8'hAB};
    expl = '{1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    b_out_ready = 1; b_in_valid = 1; b_in_data = 32'hABCDEF01; b_in_last = 1;
    @(negedge clk);
    b_in_valid = 0; b_in_last = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (b_out_valid !== 1'b1 || b_out_byte !== exp[i] || b_out_last !== expl[i]) begin
        miscompares++;
        $display("FAIL lsb_byte%0d: got valid=%b byte=%h last=%b want 1/%h/%b", i, b_out_valid, b_out_byte, b_out_last, exp[i], expl[i]);
      end
      @(negedge clk);
    end
    vectors++; if (b_out_valid !== 1'b0) begin miscompares++; $display("FAIL lsb_drain_valid: got %b want 0", b_out_valid); end
    vectors++; if (b_byte_cnt !== 32'd4) begin miscompares++; $display("FAIL lsb_byte_cnt: got %0d want 4", b_byte_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    logic [7:0]  exp [20];
    logic [31:0] t;
    int          n;
    words = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h0F1E2D3C};
    for (int w = 0; w < 5; w++)
      for (int i = 0; i < 4; i++) begin
        t = words[w] >> (24 - 8 * i);
        exp[w * 4 + i] = t[7:0];
      end
    @(negedge clk);
    a_out_ready = 0;
    for (int w = 0; w < 5; w++) begin
      vectors++; if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_ready_w%0d: got %b want 1", w, a_in_ready); end
      a_in_valid = 1; a_in_data = words[w];
      @(negedge clk);
    end
    a_in_data = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (a_level !== 3'd4 || a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_byte !== 8'h11) begin
        miscompares++;
        $display("FAIL bp_full%0d: got level=%0d ready=%b valid=%b byte=%h want 4/0/1/11", k, a_level, a_in_ready, a_out_valid, a_out_byte);
      end
      @(negedge clk);
    end
    a_in_valid = 0; a_out_ready = 1;
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 20; cyc++) begin
      if (a_out_valid) begin
        vectors++;
        if (a_out_byte !== exp[n]) begin miscompares++; $display("FAIL bp_byte%0d: got %h want %h", n, a_out_byte, exp[n]); end
        n++;
      end
      @(negedge clk);
    end
    vectors++; if (n != 20) begin miscompares++; $display("FAIL bp_timeout: got %0d bytes want 20", n); end
    vectors++; if (a_out_valid !== 1'b0 || a_level !== 3'd0) begin miscompares++; $display("FAIL bp_drain: got valid=%b level=%0d want 0/0", a_out_valid, a_level); end
    vectors++; if (a_byte_cnt !== 32'd28) begin miscompares++; $display("FAIL bp_byte_cnt: got %0d want 28", a_byte_cnt); end
  endtask

  task automatic test_random_stalls();
    logic [7:0] q [$];
    logic       lq [$];
    @(negedge clk);
    fork
      begin
        logic [31:0] d, t;
        logic        l;
        int          g;
        for (int w = 0; w < 1000; w++) begin
          d = $urandom;
          l = ($urandom_range(0, 3) == 0);
          a_in_valid = 1; a_in_data = d; a_in_last = l;
          g = 0;
          while (!a_in_ready && g < 200) begin @(negedge clk); g++; end
          if (g >= 200) begin
            vectors++; miscompares++;
            $display("FAIL rand_push_timeout: got in_ready=%b want 1 at word %0d", a_in_ready, w);
            break;
          end
          for (int i = 0; i < 4; i++) begin
            t = d >> (24 - 8 * i);
            q.push_back(t[7:0]);
            lq.push_back(l && (i == 3));
          end
          @(negedge clk);
        end
        a_in_valid = 0; a_in_last = 0;
      end
      begin
        int         got, cyc;
        logic       prev_stall, el;
        logic [7:0] prev_byte, eb;
        got = 0; cyc = 0; prev_stall = 0; prev_byte = '0;
        while (got < 4000 && cyc < 20000) begin
          a_out_ready = 1'($urandom_range(0, 1));
          vectors++; if (a_level > 3'd4) begin miscompares++; $display("FAIL rand_level: got %0d want <=4", a_level); end
          if (prev_stall) begin
            vectors++;
            if (a_out_valid !== 1'b1 || a_out_byte !== prev_byte) begin
              miscompares++;
              $display("FAIL rand_stall_hold: got valid=%b byte=%h want 1/%h", a_out_valid, a_out_byte, prev_byte);
            end
          end
          if (a_out_valid && a_out_ready) begin
            vectors++;
            if (q.size() == 0) begin
              miscompares++; $display("FAIL rand_extra_byte: got %h want none", a_out_byte);
            end else begin
              eb = q.pop_front(); el = lq.pop_front();
              if (a_out_byte !== eb || a_out_last !== el) begin
                miscompares++;
                $display("FAIL rand_byte%0d: got %h/%b want %h/%b", got, a_out_byte, a_out_last, eb, el);
              end
            end
            got++;
          end
          prev_stall = a_out_valid && !a_out_ready;
          prev_byte  = a_out_byte;
          @(negedge clk);
          cyc++;
        end
        vectors++; if (got != 4000) begin miscompares++; $display("FAIL rand_timeout: got %0d bytes want 4000", got); end
        a_out_ready = 1;
      end
    join
    vectors++; if (a_byte_cnt !== 32'd4028) begin miscompares++; $display("FAIL rand_byte_cnt: got %0d want 4028", a_byte_cnt); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4];
    exp = '{8'h55, 8'h66, 8'h77, 8'h88};
    @(negedge clk);
    a_out_ready = 1; a_in_valid = 1; a_in_data = 32'hA1B2C3D4; a_in_last = 1;
    @(negedge clk);
    a_in_data = 32'h11223344; a_in_last = 0;
    @(negedge clk);
    a_in_valid = 0;
    vectors++; if (a_out_byte !== 8'hA1) begin miscompares++; $display("FAIL rst_pre_b0: got %h want a1", a_out_byte); end
    @(negedge clk);
    vectors++; if (a_out_byte !== 8'hB2) begin miscompares++; $display("FAIL rst_pre_b1: got %h want b2", a_out_byte); end
    @(negedge clk);
    vectors++; if (a_out_valid !== 1'b1 || a_level !== 3'd1) begin miscompares++; $display("FAIL rst_pre_state: got valid=%b level=%0d want 1/1", a_out_valid, a_level); end
    rst_n = 1'b0;
    #1;
    vectors++; if (a_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b want 0", a_out_valid); end
    vectors++; if (a_level !== 3'd0) begin miscompares++; $display("FAIL rst_mid_level: got %0d want 0", a_level); end
    vectors++; if (a_byte_cnt !== 32'd0) begin miscompares++; $display("FAIL rst_mid_byte_cnt: got %0d want 0", a_byte_cnt); end
    vectors++; if (a_out_last !== 1'b0 || a_out_byte !== 8'h00) begin miscompares++; $display("FAIL rst_mid_out: got last=%b byte=%h want 0/00", a_out_last, a_out_byte); end
    @(negedge clk);
    rst_n = 1'b1;
    a_in_valid = 1; a_in_data = 32'h55667788; a_in_last = 0;
    @(negedge clk);
    a_in_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (a_out_valid !== 1'b1 || a_out_byte !== exp[i] || a_out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_after_byte%0d: got valid=%b byte=%h last=%b want 1/%h/0", i, a_out_valid, a_out_byte, a_out_last, exp[i]);
      end
      @(negedge clk);
    end
    vectors++; if (a_out_valid !== 1'b0 || a_byte_cnt !== 32'd4) begin miscompares++; $display("FAIL rst_after_drain: got valid=%b cnt=%0d want 0/4", a_out_valid, a_byte_cnt); end
  endtask

  task automatic test_byte_wrap();
    @(negedge clk);
    c_out_ready = 1;
    fork
      begin
        int g;
        for (int i = 0; i < 20; i++) begin
          c_in_valid = 1; c_in_data = c_word(i); c_in_last = ((i % 3) == 2);
          g = 0;
          while (!c_in_ready && g < 50) begin @(negedge clk); g++; end
          @(negedge clk);
        end
        c_in_valid = 0; c_in_last = 0;
      end
      begin
        int got;
        got = 0;
        for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
          if (c_out_valid) begin
            vectors++;
            if (c_out_byte !== c_word(got) || c_out_last !== ((got % 3) == 2)) begin
              miscompares++;
              $display("FAIL wrap_byte%0d: got %h/%b want %h/%b", got, c_out_byte, c_out_last, c_word(got), ((got % 3) == 2));
            end
            got++;
          end
          @(negedge clk);
        end
        vectors++; if (got != 20) begin miscompares++; $display("FAIL wrap_timeout: got %0d bytes want 20", got); end
      end
    join
    vectors++; if (c_byte_cnt !== 4'd4) begin miscompares++; $display("FAIL wrap_byte_cnt: got %0d want 4", c_byte_cnt); end
    vectors++; if (c_out_valid !== 1'b0 || c_level !== 3'd0) begin miscompares++; $display("FAIL wrap_drain: got valid=%b level=%0d want 0/0", c_out_valid, c_level); end
  endtask

  initial begin
    test_reset();
    test_msb_order();
    test_lsb_last();
    test_backpressure();
    test_random_stalls();
    test_reset_mid_word();
    test_byte_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
